// File: rtl/angular_tap_sum_if.sv
// Tap-in / sample-out handshake bundle for angular_tap_sum.
// A beat moves on a rising edge where valid and ready are both 1; valid must not depend on ready.
interface angular_tap_sum_if #(
  parameter int BITDEPTH = 8
);
  logic                in_valid;
  logic                in_ready;
  logic signed [15:0]  in_prod;
  logic                in_last;
  logic                out_valid;
  logic                out_ready;
  logic [BITDEPTH-1:0] out_sample;
  logic                tap_err;

  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_sample, tap_err
  );

  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_sample, tap_err
  );
endinterface

// File: rtl/angular_tap_sum.sv
// Accumulates NTAPS signed tap products, then rounds, shifts and clips them to one
// BITDEPTH-bit prediction sample; a misplaced in_last raises a one-cycle tap_err.
module angular_tap_sum #(
  parameter int NTAPS    = 4,
  parameter int SHIFT    = 6,
  parameter int BITDEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  angular_tap_sum_if.slave  bus
);
  localparam int CNT_W = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int ACC_W = 16 + $clog2(NTAPS);
  // Two extra bits keep the rounding offset from overflowing a full-scale sum.
  localparam int SUM_W = ACC_W + 2;

  localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(NTAPS - 1);
  localparam logic signed [SUM_W-1:0] ROUND    = SUM_W'(2 ** (SHIFT - 1));
  localparam logic signed [SUM_W-1:0] MAX_S    = SUM_W'(2 ** BITDEPTH - 1);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic [BITDEPTH-1:0]     out_sample_q, out_sample_d;
  logic                    tap_err_q, tap_err_d;

  logic                    in_ready_w;
  logic                    accept;
  logic                    at_last_cnt;
  logic signed [SUM_W-1:0] sum_w;
  logic signed [SUM_W-1:0] rnd_w;
  logic signed [SUM_W-1:0] r_w;
  logic [BITDEPTH-1:0]     clip_w;

  // A held, unconsumed result freezes the input side so acc/cnt cannot move.
  assign in_ready_w  = ~(out_valid_q & ~bus.out_ready);
  assign accept      = bus.in_valid & in_ready_w;
  assign at_last_cnt = (cnt_q == LAST_CNT);

  always_comb begin
    sum_w = SUM_W'(acc_q) + SUM_W'(bus.in_prod);
    rnd_w = sum_w + ROUND;
    r_w   = rnd_w >>> SHIFT;
    if (r_w[SUM_W-1]) begin
      clip_w = '0;
    end else if (r_w > MAX_S) begin
      clip_w = MAX_S[BITDEPTH-1:0];
    end else begin
      clip_w = r_w[BITDEPTH-1:0];
    end
  end

  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q & ~bus.out_ready;
    out_sample_d = out_sample_q;
    tap_err_d    = 1'b0;
    if (accept) begin
      if (bus.in_last && at_last_cnt) begin
        out_valid_d  = 1'b1;
        out_sample_d = clip_w;
        acc_d        = '0;
        cnt_d        = '0;
      end else if (bus.in_last != at_last_cnt) begin
        // Tap count and in_last disagree: drop the partial sample entirely.
        tap_err_d = 1'b1;
        acc_d     = '0;
        cnt_d     = '0;
      end else begin
        acc_d = acc_q + ACC_W'(bus.in_prod);
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
      tap_err_q    <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_sample_q <= out_sample_d;
      tap_err_q    <= tap_err_d;
    end
  end

  assign bus.in_ready   = in_ready_w;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_sample = out_sample_q;
  assign bus.tap_err    = tap_err_q;
endmodule

// File: doc/angular_tap_sum.md
ANGULAR_TAP_SUM -- requirements
Module: angular_tap_sum

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk is the single clock, and rst_n is a synchronous reset asserted low and sampled on the rising edge of clk.
REQ-002 Parameter NTAPS, default 4: number of tap products summed per output sample.
REQ-003 Parameter SHIFT, default 6: normalisation shift; the rounding offset is 2^(SHIFT-1).
REQ-004 Parameter BITDEPTH, default 8: output sample width; the clip range is 0..2^BITDEPTH-1.
REQ-005 Ports, in order:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  in_prod/in_last are valid.
- in_ready  out  1  block accepts a tap this cycle.
- in_prod  in  16 signed  one coefficient-times-sample product from the constant-multiplier stage.
- in_last  in  1  marks the final tap of a sample.
- out_valid  out  1  out_sample is valid.
- out_ready  in  1  downstream accepts out_sample.
- out_sample  out  BITDEPTH unsigned  filtered, rounded, clipped prediction sample.
- tap_err  out  1  one-cycle pulse on a tap-count mismatch.

Function
REQ-006 A tap SHALL be accepted only on a cycle where in_valid and in_ready are both 1.
REQ-007 in_ready SHALL equal NOT(out_valid AND NOT out_ready), combinationally.
REQ-008 The block SHALL hold an 18-bit signed accumulator acc and a tap counter cnt in the range 0..NTAPS-1.
REQ-009 On an accepted tap with cnt < NTAPS-1 and in_last=0, the block SHALL set acc <= acc + sign-extended in_prod and cnt <= cnt+1.
REQ-010 On an accepted tap with cnt = NTAPS-1 and in_last=1, the block SHALL compute sum = acc + in_prod.
REQ-011 In that case it SHALL compute r = (sum + 2^(SHIFT-1)) arithmetic-shifted right by SHIFT, i.e. floor division.
REQ-012 In that case it SHALL register out_sample <= clip(r, 0, 2^BITDEPTH-1) and out_valid <= 1 on the same edge.
REQ-013 In that case it SHALL also clear acc and cnt to 0. Latency is one clock from the last-tap acceptance edge to out_valid=1.
REQ-014 A mismatch SHALL be either an accepted tap with in_last=1 and cnt < NTAPS-1, or an accepted tap with in_last=0 and cnt = NTAPS-1.
REQ-015 On a mismatch, the block SHALL pulse tap_err=1 for exactly one cycle, clear acc and cnt, discard the tap, and produce no output.
REQ-016 out_valid SHALL clear on the cycle after out_valid AND out_ready, unless a new last tap is accepted in that same cycle.
REQ-017 If a new last tap is accepted while the current output is consumed, out_valid SHALL stay 1 and out_sample SHALL update to the new result, with no bubble.
REQ-018 While out_valid=1 and out_ready=0, out_sample SHALL be held stable, and acc and cnt SHALL not change.
REQ-019 Intermediate arithmetic SHALL be wide enough that NTAPS products of 16 bits cannot wrap: 18 bits for NTAPS=4, widening by ceil(log2(NTAPS)).
REQ-020 tap_err SHALL be 0 on every cycle other than a mismatch cycle.

Reset
REQ-021 When rst_n=0 at a rising edge, the block SHALL set out_valid=0, out_sample=0, tap_err=0, acc=0 and cnt=0.
REQ-022 Reset SHALL take priority over every simultaneous accept or consume.
REQ-023 A partially accumulated sample SHALL be discarded by reset, and the next accepted tap SHALL be treated as tap 0.
REQ-024 in_ready SHALL be 1 during and immediately after reset.

Verification
REQ-025 Basic sum: taps 0, 6400, 0, 0 (in_last on the 4th) with out_ready=1 -> out_valid=1 one cycle later with out_sample=100, and tap_err stays 0.
REQ-026 Rounding and clip: tap sums of 31, 32, -1530 and 24000 (each as 4 taps) -> out_sample of 0, 1, 0 (r=-24 clipped) and 255 (r=375 clipped), respectively.
REQ-027 Backpressure: a result is produced, out_ready is held 0 for 3 cycles, then 1 -> out_sample is stable and in_ready=0 for those 3 cycles, then exactly one transfer occurs.
REQ-028 Tap error: in_last=1 on the 2nd tap -> tap_err=1 for one cycle, no out_valid; the next 4 taps 64, 64, 64, 64 -> out_sample=4.
REQ-029 Reset mid-sample: 2 taps of 6400 accepted, then rst_n=0 for one cycle, then taps 0, 640, 0, 0 -> out_sample=10, not 210.
REQ-030 Back-to-back: eight samples streamed with continuous in_valid and out_ready=1 -> eight outputs, one per 4 accepted taps, with no dropped or duplicated sample.
